// File: rtl/ahb_dec_mux.sv
// ---------------------------------------------------------------------------
// ahb_dec_mux
//   AHB-Lite address decoder and response multiplexer for a single master.
//   Decodes haddr against per-slave base/mask pairs (lowest index wins),
//   remembers the selected slave for the data phase and routes that slave's
//   hrdata/hreadyout/hresp back to the master. Unmapped accesses go to a
//   built-in default slave (DS) that answers NONSEQ/SEQ with the two-cycle
//   ERROR response and counts/logs each decode error.
//
// Ports
//   hclk, hreset            clock, synchronous active-high reset
//   haddr_base/haddr_mask   per-slave decode window (mask bit 1 = compared)
//   haddr, htrans           master address-phase signals
//   hsel                    one-hot slave select (all-zero when unmapped)
//   hrdata_s/hreadyout_s/hresp_s  per-slave data-phase responses
//   hrdata, hready, hresp   muxed response to the master (hready also fans
//                           out to every slave's hready input)
//   err_cnt, err_addr       saturating decode-error count, last error haddr
//   ds_state                default-slave FSM state (debug observation)
//
// Handshake: an address phase is accepted on a rising edge where hready = 1;
// while hready = 0 the master holds its address phase and nothing here moves
// except the DS FSM stepping out of ERR1.
// ---------------------------------------------------------------------------
module ahb_dec_mux #(
  parameter int slv_c = 4,
  parameter int cnt_w = 16
) (
  input  logic                        hclk,
  input  logic                        hreset,
  input  logic [slv_c-1:0][31:0]      haddr_base,
  input  logic [slv_c-1:0][31:0]      haddr_mask,
  input  logic [31:0]                 haddr,
  input  logic [1:0]                  htrans,
  output logic [slv_c-1:0]            hsel,
  input  logic [slv_c-1:0][31:0]      hrdata_s,
  input  logic [slv_c-1:0]            hreadyout_s,
  input  logic [slv_c-1:0]            hresp_s,
  output logic [31:0]                 hrdata,
  output logic                        hready,
  output logic                        hresp,
  output logic [cnt_w-1:0]            err_cnt,
  output logic [31:0]                 err_addr,
  output logic [1:0]                  ds_state
);

  localparam int IW = (slv_c > 1) ? $clog2(slv_c) : 1;

  localparam logic [1:0] DS_IDLE = 2'd0;
  localparam logic [1:0] DS_ERR1 = 2'd1;
  localparam logic [1:0] DS_ERR2 = 2'd2;

  logic          hit;
  logic [IW-1:0] sel_idx;
  logic          ds_err;

  logic          dsel_ds_q, dsel_ds_d;
  logic [IW-1:0] dsel_q, dsel_d;
  logic [1:0]    state_q, state_d;
  logic [cnt_w-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]   err_addr_q, err_addr_d;

  // Only htrans[1] distinguishes NONSEQ/SEQ from IDLE/BUSY for the DS.
  logic unused_htrans0;
  assign unused_htrans0 = htrans[0];

  // Scan from the top index down so the lowest matching index is the one
  // left in sel_idx.
  always_comb begin
    hit     = 1'b0;
    sel_idx = '0;
    for (int i = slv_c - 1; i >= 0; i--) begin
      if ((haddr & haddr_mask[i]) == (haddr_base[i] & haddr_mask[i])) begin
        hit     = 1'b1;
        sel_idx = IW'(i);
      end
    end
  end

  always_comb begin
    hsel = '0;
    if (hit) hsel[sel_idx] = 1'b1;
  end

  // An accepted NONSEQ/SEQ with no matching slave.
  assign ds_err = hready & ~hit & htrans[1];

  // Data-phase select follows the decode only when the address is accepted.
  always_comb begin
    dsel_ds_d = dsel_ds_q;
    dsel_d    = dsel_q;
    if (hready) begin
      dsel_ds_d = ~hit;
      dsel_d    = sel_idx;
    end
  end

  always_comb begin
    state_d = DS_IDLE;
    case (state_q)
      DS_IDLE: state_d = ds_err ? DS_ERR1 : DS_IDLE;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = ds_err ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_comb begin
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    if (ds_err) begin
      err_addr_d = haddr;
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + cnt_w'(1);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      dsel_ds_q  <= 1'b1;
      dsel_q     <= '0;
      state_q    <= DS_IDLE;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      dsel_ds_q  <= dsel_ds_d;
      dsel_q     <= dsel_d;
      state_q    <= state_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Response mux. The DS is ready except in ERR1 and flags ERROR in both
  // ERR1 and ERR2.
  always_comb begin
    if (dsel_ds_q) begin
      hrdata = '0;
      hready = (state_q != DS_ERR1);
      hresp  = (state_q != DS_IDLE);
    end else begin
      hrdata = hrdata_s[dsel_q];
      hready = hreadyout_s[dsel_q];
      hresp  = hresp_s[dsel_q];
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
  assign ds_state = state_q;

endmodule

// File: tb/tb_ahb_dec_mux.sv
module tb_ahb_dec_mux;

  logic             hclk;
  logic             hreset;
  logic [3:0][31:0] haddr_base;
  logic [3:0][31:0] haddr_mask;
  logic [31:0]      haddr;
  logic [1:0]       htrans;
  logic [3:0][31:0] hrdata_s;
  logic [3:0]       hreadyout_s;
  logic [3:0]       hresp_s;

  logic [3:0]       hsel,     hsel_b;
  logic [31:0]      hrdata,   hrdata_b;
  logic             hready,   hready_b;
  logic             hresp,    hresp_b;
  logic [15:0]      err_cnt;
  logic [3:0]       err_cnt_b;
  logic [31:0]      err_addr, err_addr_b;
  logic [1:0]       ds_state, ds_state_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference bookkeeping for the decode-error counters.
  int          exp_errs  = 0;
  logic [31:0] exp_eaddr = 32'h0;

  // ---------------- clock ----------------
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // ---------------- DUTs -----------------
  ahb_dec_mux #(.slv_c(4), .cnt_w(16)) u_dut (
    .hclk(hclk), .hreset(hreset),
    .haddr_base(haddr_base), .haddr_mask(haddr_mask),
    .haddr(haddr), .htrans(htrans), .hsel(hsel),
    .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s),
    .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .err_cnt(err_cnt), .err_addr(err_addr), .ds_state(ds_state)
  );

  ahb_dec_mux #(.slv_c(4), .cnt_w(4)) u_sat (
    .hclk(hclk), .hreset(hreset),
    .haddr_base(haddr_base), .haddr_mask(haddr_mask),
    .haddr(haddr), .htrans(htrans), .hsel(hsel_b),
    .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s),
    .hrdata(hrdata_b), .hready(hready_b), .hresp(hresp_b),
    .err_cnt(err_cnt_b), .err_addr(err_addr_b), .ds_state(ds_state_b)
  );

  // ---------------- helpers --------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  // Sample point: falling edge.
  task automatic smp();
    @(negedge hclk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    haddr  = a;
    htrans = t;
  endtask

  // First matching slave index, lowest wins; -1 when unmapped.
  function automatic int decode_idx(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if (((a ^ haddr_base[i]) & haddr_mask[i]) == 32'h0) return i;
    return -1;
  endfunction

  function automatic logic [3:0] exp_hsel(input logic [31:0] a);
    int k;
    logic [3:0] one;
    k   = decode_idx(a);
    one = 4'b0001;
    return (k < 0) ? 4'b0000 : (one << k);
  endfunction

  task automatic chk_bus(input string tag, input logic rdy, input logic rsp);
    chk({tag, "_hready"}, {31'h0, hready}, {31'h0, rdy});
    chk({tag, "_hresp"},  {31'h0, hresp},  {31'h0, rsp});
  endtask

  task automatic chk_err(input string tag);
    int sat;
    sat = (exp_errs > 15) ? 15 : exp_errs;
    chk({tag, "_err_cnt"},   {16'h0, err_cnt}, 32'(exp_errs));
    chk({tag, "_err_addr"},  err_addr, exp_eaddr);
    chk({tag, "_sat_cnt"},   {28'h0, err_cnt_b}, 32'(sat));
  endtask

  // One random transfer followed by a parked IDLE to slave 0, with the
  // expected data-phase response derived from the decode rules.
  task automatic rand_xfer(input logic [31:0] a, input logic [1:0] t);
    int k;
    cyc();
    for (int i = 0; i < 4; i++) begin
      hrdata_s[i] = $urandom;
      hresp_s[i]  = 1'($urandom_range(0, 1));
    end
    drive(a, t);
    k = decode_idx(a);
    smp();
    chk("rnd_hsel", {28'h0, hsel}, {28'h0, exp_hsel(a)});
    cyc();
    drive(32'h0, 2'b00);
    smp();
    if (k < 0 && t[1]) begin
      exp_errs++;
      exp_eaddr = a;
      chk_bus("rnd_err1", 1'b0, 1'b1);
      chk("rnd_err1_hrdata", hrdata, 32'h0);
      chk_err("rnd_err1");
      cyc();
      smp();
      chk_bus("rnd_err2", 1'b1, 1'b1);
    end else if (k < 0) begin
      chk_bus("rnd_ds_ok", 1'b1, 1'b0);
      chk("rnd_ds_hrdata", hrdata, 32'h0);
      chk_err("rnd_ds_ok");
    end else begin
      chk_bus("rnd_slv", hreadyout_s[k], hresp_s[k]);
      chk("rnd_slv_hrdata", hrdata, hrdata_s[k]);
    end
  endtask

  // ---------------- stimulus -------------
  initial begin
    logic [3:0]  nib;
    logic [31:0] a;
    int          j;

    hreset      = 1'b1;
    haddr_base  = {32'h2000_0000, 32'h1000_0000, 32'h1000_0000, 32'h0000_0000};
    haddr_mask  = {4{32'hF000_0000}};
    hrdata_s    = '0;
    hreadyout_s = 4'hF;
    hresp_s     = 4'h0;
    drive(32'h3000_0000, 2'b00);

    // Reset values.
    cyc();
    cyc();
    smp();
    chk_bus("reset", 1'b1, 1'b0);
    chk("reset_hrdata", hrdata, 32'h0);
    chk_err("reset");
    cyc();
    hreset = 1'b0;

    // Decode and priority.
    drive(32'h1000_0040, 2'b00);
    smp();
    chk("dec_overlap", {28'h0, hsel}, 32'h2);
    cyc();
    drive(32'h2FFF_FFFC, 2'b00);
    smp();
    chk("dec_slv3", {28'h0, hsel}, 32'h8);
    cyc();
    drive(32'h3000_0000, 2'b00);
    smp();
    chk("dec_none", {28'h0, hsel}, 32'h0);

    // Read through slave 1 with two wait states.
    cyc();
    drive(32'h1000_0000, 2'b10);
    hreadyout_s[1] = 1'b0;
    smp();
    chk("rd_addr_hready", {31'h0, hready}, 32'h1);
    cyc();
    drive(32'h0, 2'b00);
    smp();
    chk_bus("rd_wait1", 1'b0, 1'b0);
    cyc();
    smp();
    chk_bus("rd_wait2", 1'b0, 1'b0);
    cyc();
    hreadyout_s[1] = 1'b1;
    hrdata_s[1]    = 32'hDEAD_BEEF;
    smp();
    chk_bus("rd_done", 1'b1, 1'b0);
    chk("rd_hrdata", hrdata, 32'hDEAD_BEEF);

    // Single unmapped NONSEQ.
    cyc();
    drive(32'h3000_0010, 2'b10);
    cyc();
    drive(32'h0, 2'b00);
    exp_errs++;
    exp_eaddr = 32'h3000_0010;
    smp();
    chk_bus("err_c1", 1'b0, 1'b1);
    chk_err("err_c1");
    cyc();
    smp();
    chk_bus("err_c2", 1'b1, 1'b1);
    cyc();
    smp();
    chk_bus("err_after", 1'b1, 1'b0);

    // Back-to-back unmapped NONSEQ; second address is held through ERR1
    // and accepted in ERR2.
    cyc();
    drive(32'h3000_0020, 2'b10);
    cyc();
    drive(32'h3000_0030, 2'b10);
    exp_errs++;
    exp_eaddr = 32'h3000_0020;
    smp();
    chk_bus("b2b_c1", 1'b0, 1'b1);
    chk_err("b2b_c1");
    cyc();
    smp();
    chk_bus("b2b_c2", 1'b1, 1'b1);
    cyc();
    drive(32'h0, 2'b00);
    exp_errs++;
    exp_eaddr = 32'h3000_0030;
    smp();
    chk_bus("b2b_c3", 1'b0, 1'b1);
    chk_err("b2b_c3");
    cyc();
    smp();
    chk_bus("b2b_c4", 1'b1, 1'b1);
    cyc();
    smp();
    chk_bus("b2b_after", 1'b1, 1'b0);

    // IDLE to an unmapped address: OKAY, no error counted.
    cyc();
    drive(32'h3000_0000, 2'b00);
    cyc();
    drive(32'h0, 2'b00);
    smp();
    chk_bus("idle_ds", 1'b1, 1'b0);
    chk("idle_ds_hrdata", hrdata, 32'h0);
    chk_err("idle_ds");

    // Reset asserted in ERR1.
    cyc();
    drive(32'h3000_0040, 2'b10);
    cyc();
    drive(32'h0, 2'b00);
    smp();
    chk_bus("rst_err1", 1'b0, 1'b1);
    hreset = 1'b1;
    cyc();
    hreset    = 1'b0;
    exp_errs  = 0;
    exp_eaddr = 32'h0;
    smp();
    chk_bus("rst_after", 1'b1, 1'b0);
    chk_err("rst_after");

    // Seventeen errors: the 4-bit counter must stick at all-ones.
    for (int n = 0; n < 17; n++) begin
      a = 32'h3000_1000 + 32'(n * 4);
      cyc();
      drive(a, 2'b11);
      cyc();
      drive(32'h0, 2'b00);
      exp_errs++;
      exp_eaddr = a;
      smp();
      chk_err("sat");
      cyc();
    end
    smp();
    chk("sat_final", {28'h0, err_cnt_b}, 32'hF);

    // Randomized transfers against the reference rules.
    for (int n = 0; n < 60; n++) begin
      nib = 4'($urandom_range(0, 4));
      a   = {nib, 28'($urandom)} & 32'hFFFF_FFFC;
      rand_xfer(a, 2'($urandom_range(0, 3)));
    end

    // Randomized decode tables, combinational hsel only.
    for (int n = 0; n < 40; n++) begin
      cyc();
      for (int i = 0; i < 4; i++) begin
        haddr_mask[i] = $urandom & 32'hFFF0_0000;
        haddr_base[i] = $urandom;
      end
      j = int'($urandom_range(0, 4));
      if (j < 4) a = (haddr_base[j] & haddr_mask[j]) | ($urandom & ~haddr_mask[j]);
      else       a = $urandom;
      drive(a, 2'b00);
      smp();
      chk("rnd_table_hsel", {28'h0, hsel}, {28'h0, exp_hsel(a)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
